// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - op codes, sequencer states and decode helpers shared by alu_md
package alu_md_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_ADDU  = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_OR    = 5'b00101;
  localparam logic [4:0] OP_SLT   = 5'b00110;
  localparam logic [4:0] OP_LUI   = 5'b00111;
  localparam logic [4:0] OP_CMP   = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_NOR   = 5'b01010;
  localparam logic [4:0] OP_SLL   = 5'b01011;
  localparam logic [4:0] OP_SRL   = 5'b01100;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_MULT  = 5'b01110;
  localparam logic [4:0] OP_MULTU = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_DIVU  = 5'b10001;
  localparam logic [4:0] OP_MFHI  = 5'b10010;
  localparam logic [4:0] OP_MFLO  = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } seq_state_e;

  // Ops that start the multiply/divide sequencer; DIV/DIVU only exist with the divider built in.
  function automatic logic is_long_op(input logic [4:0] aluop);
    logic r;
    r = (aluop == OP_MULT) || (aluop == OP_MULTU);
`ifdef ALU_DIV_EN
    r = r || (aluop == OP_DIV) || (aluop == OP_DIVU);
`endif
    return r;
  endfunction

  function automatic logic is_hilo_op(input logic [4:0] aluop);
    return is_long_op(aluop) || (aluop == OP_MFHI) || (aluop == OP_MFLO);
  endfunction

endpackage

// File: rtl/alu_md_seq.sv
// rtl/alu_md_seq.sv - iterative shift-add multiplier / restoring divider writing HI/LO
// Divider datapath and DIV state exist only when ALU_DIV_EN is defined.
module alu_md_seq
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_signed, sign_a, sign_b, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod;
`ifdef ALU_DIV_EN
  logic               is_div, div_ge;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo, rem;
`endif

  always_comb begin
    // Divide by zero runs unsigned so HI ends up holding a untouched.
    is_signed = (aluop == OP_MULT);
`ifdef ALU_DIV_EN
    is_div    = (aluop == OP_DIV) || (aluop == OP_DIVU);
    is_signed = is_signed || ((aluop == OP_DIV) && (b != '0));
`endif
    sign_a = is_signed & a[WIDTH-1];
    sign_b = is_signed & b[WIDTH-1];
    mag_a  = sign_a ? -a : a;
    mag_b  = sign_b ? -b : b;
    last   = (cnt_q == CNT_W'(WIDTH - 1));

    // acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_res_q ? -mul_next : mul_next;

`ifdef ALU_DIV_EN
    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    quo       = div_next[WIDTH-1:0];
    rem       = div_next[2*WIDTH-1:WIDTH];
`endif

    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          opnd_d    = mag_a;
          acc_d     = {{WIDTH{1'b0}}, mag_b};
          state_d   = ST_MUL;
`ifdef ALU_DIV_EN
          if (is_div) begin
            opnd_d  = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = ST_DIV;
          end
`endif
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          {hi_d, lo_d} = prod;
          state_d      = ST_IDLE;
        end
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          lo_d    = neg_res_q ? -quo : quo;
          hi_d    = neg_rem_q ? -rem : rem;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - EX-stage ALU: single-cycle ops, HI/LO moves and multiply/divide stall control
// Define ALU_DIV_EN to build the DIV/DIVU divider; otherwise those codes act as unknown ops.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             ovf,
  output logic             stall,
  output logic             busy
);

  logic [WIDTH-1:0]   hi, lo, sum, diff;
  logic [SHAMT_W-1:0] shamt;
  logic               start;

  assign shamt = b[SHAMT_W-1:0];
  assign sum   = a + b;
  assign diff  = a - b;
  assign zero  = op_valid & (a == b);

  // Only ops that need the sequencer or its HI/LO wait; everything else flows past a busy unit.
  assign stall = busy & op_valid & is_hilo_op(aluop);
  assign start = op_valid & ~stall & is_long_op(aluop);

  always_comb begin
    c   = '0;
    ovf = 1'b0;
    case (aluop)
      OP_ADD: begin
        c   = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: c = sum;
      OP_SUB: begin
        c   = diff;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI:  c = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_CMP:  c = '0;
      OP_XOR:  c = a ^ b;
      OP_NOR:  c = ~(a | b);
      OP_SLL:  c = a << shamt;
      OP_SRL:  c = a >> shamt;
      OP_SRA:  c = $unsigned($signed(a) >>> shamt);
      OP_MFHI: c = hi;
      OP_MFLO: c = lo;
      default: c = '0;
    endcase
  end

  alu_md_seq #(
    .WIDTH(WIDTH)
  ) u_seq (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .aluop(aluop),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - randomized scoreboard bench for alu_md against a program-order reference model
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst, op_valid;
  logic [4:0]   aluop;
  logic [W-1:0] a, b, c;
  logic         zero, ovf, stall, busy;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .aluop(aluop),
    .a(a), .b(b), .c(c), .zero(zero), .ovf(ovf), .stall(stall), .busy(busy)
  );

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] c;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
  endtask

  // Architectural model: HI/LO update in program order the moment a long op is issued.
  task automatic model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    longint sx, sy, r;
    longint unsigned ux, uy;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = x;
    uy = y;
    sh = int'(y % W);
    e.op = op; e.c = '0; e.zero = (x == y); e.ovf = 1'b0;
    case (op)
      OP_ADD:   begin r = sx + sy; e.c = W'(r); e.ovf = (r > SMAX) || (r < SMIN); end
      OP_ADDU:  e.c = x + y;
      OP_SUB:   begin r = sx - sy; e.c = W'(r); e.ovf = (r > SMAX) || (r < SMIN); end
      OP_AND:   e.c = x & y;
      OP_OR:    e.c = x | y;
      OP_SLT:   e.c = {{(W-1){1'b0}}, (sx < sy)};
      OP_LUI:   e.c = y << (W / 2);
      OP_XOR:   e.c = x ^ y;
      OP_NOR:   e.c = ~(x | y);
      OP_SLL:   e.c = x << sh;
      OP_SRL:   e.c = x >> sh;
      OP_SRA:   e.c = W'(sx >>> sh);
      OP_MULT:  {m_hi, m_lo} = sx * sy;
      OP_MULTU: {m_hi, m_lo} = ux * uy;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (y == '0) begin m_lo = '1; m_hi = x; end
        else begin m_lo = W'(sx / sy); m_hi = W'(sx % sy); end
      end
      OP_DIVU: begin
        if (y == '0) begin m_lo = '1; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
      end
`endif
      OP_MFHI:  e.c = m_hi;
      OP_MFLO:  e.c = m_lo;
      default:  e.c = '0;
    endcase
  endtask

  // Drive one instruction from posedge+1 and hold it until it is accepted.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int stalls);
    exp_t e;
    op_valid = 1'b1; aluop = op; a = x; b = y;
    model(op, x, y, e);
    exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls > 4 * W) begin
        n_checks++;
        $display("FAIL issue_timeout: op %0d stalled %0d cycles, limit %0d", op, stalls, 4 * W);
        break;
      end
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0; aluop = 5'($urandom); a = $urandom; b = $urandom;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && op_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: response for op %0d with no expected entry", aluop);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("op%0d_c", e.op), c, e.c);
        check($sformatf("op%0d_zero", e.op), W'(zero), W'(e.zero));
        check($sformatf("op%0d_ovf", e.op), W'(ovf), W'(e.ovf));
      end
    end
  end

  initial begin
    int st, cnt;
    logic [4:0] op;
    logic [W-1:0] x, y;
    rst = 1'b1; op_valid = 1'b0; aluop = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_c", c, '0);
    check("rst_zero", W'(zero), '0);
    check("rst_ovf", W'(ovf), '0);
    check("rst_stall", W'(stall), '0);
    check("rst_busy", W'(busy), '0);
    @(posedge clk);
    #1;
    issue(OP_MFHI, '0, '0, st);
    issue(OP_MFLO, '0, '0, st);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, st);
    issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1, st);
    issue(OP_SUB, 32'h8000_0000, 32'h1, st);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h0, st);
    issue(OP_SRA, 32'h8000_0000, 32'h4, st);
    issue(OP_LUI, 32'h0, 32'h1234, st);
    issue(OP_CMP, 32'h5, 32'h5, st);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, st);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || cnt > 4 * W) break;
      cnt++;
    end
    check("mult_busy_cycles", W'(cnt), W'(W));
    @(posedge clk);
    #1;
    issue(OP_MFHI, '0, '0, st);
    issue(OP_MFLO, '0, '0, st);

    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, st);
    issue(OP_MFLO, '0, '0, st);
    check("mflo_stall_cycles", W'(st), W'(W));

    issue(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, st);
    issue(OP_ADD, 32'h0000_00FF, 32'h0000_0001, st);
    check("add_while_busy_stall", W'(st), '0);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, st);
    check("mult_b2b_stall", W'(st), W'(W - 1));
    @(negedge clk);
    check("mult_b2b_busy", W'(busy), 1);
    @(posedge clk);
    #1;
    issue(OP_MFHI, '0, '0, st);

`ifdef ALU_DIV_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, st);
    issue(OP_MFLO, '0, '0, st);
    issue(OP_MFHI, '0, '0, st);
    issue(OP_DIVU, 32'h9, 32'h0, st);
    issue(OP_MFLO, '0, '0, st);
    issue(OP_MFHI, '0, '0, st);
`else
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, st);
    check("div_off_stall", W'(st), '0);
    @(negedge clk);
    check("div_off_busy", W'(busy), '0);
    @(posedge clk);
    #1;
`endif

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, st);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check("rst_abort_busy", W'(busy), '0);
    @(posedge clk);
    #1;
    issue(OP_MFHI, '0, '0, st);
    issue(OP_MFLO, '0, '0, st);

    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      x = pick();
      y = pick();
      issue(op, x, y, st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    issue(OP_MFHI, '0, '0, st);
    issue(OP_MFLO, '0, '0, st);

    check("sb_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised EX-stage ALU for the pipelined CPU, successor to the single-cycle 5-bit-opcode ALU. Single-cycle ops (arithmetic, logic, shifts, compare) resolve combinationally in the EX cycle. Multiply and divide run iteratively into internal HI/LO registers. A stall output holds the pipeline only when an instruction needs the busy multiply/divide unit or its HI/LO results.

## Interface
- WIDTH, 32, datapath width; even, at least 8
- SHAMT_W, $clog2(WIDTH), shift-amount width taken from b[SHAMT_W-1:0]
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous reset, active-high
- op_valid  input  1  EX stage holds a valid instruction this cycle
- aluop  input  5  operation code (see Operation)
- a, b  input  WIDTH each  operands (a = rs, b = rt/immediate)
- c  output  WIDTH  combinational result
- zero  output  1  a == b; valid for every op, never latched
- ovf  output  1  signed overflow for ADD/SUB, otherwise 0
- stall  output  1  combinational; holds IF/ID/EX this cycle
- busy  output  1  registered; multiply/divide in progress

## Operation
- Op codes:
  - 00001 ADD (signed, ovf)
  - 00010 ADDU
  - 00011 SUB (signed, ovf)
  - 00100 AND
  - 00101 OR
  - 00110 SLT: signed, result 1 else 0
  - 00111 LUI: b[WIDTH/2-1:0] placed in the upper half, zeros below
  - 01000 CMP: c = 0, zero only
  - 01001 XOR
  - 01010 NOR
  - 01011 SLL
  - 01100 SRL
  - 01101 SRA
  - 01110 MULT
  - 01111 MULTU
  - 10000 DIV
  - 10001 DIVU
  - 10010 MFHI
  - 10011 MFLO
  - any other code: c = 0
- Results of MULT, MULTU, DIV and DIVU go only to HI/LO; c = 0 for these ops.
- Operation is accepted when op_valid=1 and stall=0.
- State machine (state register in alu_md_seq):
  - IDLE -> MUL on accepted MULT/MULTU.
  - IDLE -> DIV on accepted DIV/DIVU.
  - MUL/DIV run WIDTH iterations, then return to IDLE, writing HI/LO on that edge.
  - busy = (state != IDLE).
- Multiply:
  - Shift-add, one bit per cycle, on operand magnitudes.
  - Signed: the 2·WIDTH product is negated at the end if the operand signs differ.
  - {HI,LO} = the 2·WIDTH product.
- Divide:
  - Restoring, one bit per cycle, on operand magnitudes.
  - LO = quotient, HI = remainder.
  - Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Divide by zero: full WIDTH cycles, then LO = all ones and HI = a (unsigned magnitude path, no sign fix-up).
- stall = busy & op_valid & (op is MULT/MULTU/DIV/DIVU/MFHI/MFLO). Other ops proceed while busy.
- MFHI/MFLO while idle: c = HI/LO combinationally.
- Operands are captured into the sequencer on acceptance. Later changes on a/b do not disturb an operation in flight.

## Timing
- Reset values:
  - state=IDLE, busy=0, HI=0, LO=0, iteration counter=0.
  - c, zero, ovf, stall are combinational: 0 for inputs 0 and op_valid=0.
- Reset mid-operation aborts it on that edge. HI/LO are cleared and not updated from the aborted operation.
- Long-op latency:
  - Accept at edge N.
  - busy=1 during cycles N+1..N+WIDTH.
  - HI/LO valid and busy=0 after edge N+WIDTH.
  - MFHI issued during busy stalls and completes in cycle N+WIDTH+1.
- A back-to-back MULT after MULT stalls until busy falls, then is accepted in that same cycle (zero-bubble restart).
- op_valid=0 never changes state, except for the iteration of an operation already running.

## Configuration
- ALU_DIV_EN
  - Defined: divider datapath and DIV state present.
  - Undefined: DIV/DIVU decode as unknown ops (c=0, no state change, no stall). The DIV state and restoring datapath are not synthesised.
  - Multiply behaviour is identical either way.

## Structure
- Package alu_md_pkg holds:
  - the 5-bit op-code localparams
  - state encoding (IDLE, MUL, DIV)
  - helper function is_long_op(aluop)
- Sub-module alu_md_seq holds the iterative multiply/divide sequencer: state, counter, operand/accumulator registers, HI/LO.
- The top level keeps the combinational ops and the stall logic.

## Test plan
- ADD a=0x7FFFFFFF, b=1 -> c=0x80000000, ovf=1. ADDU with same operands -> ovf=0. SLT a=-1, b=0 -> c=1.
- SRA a=0x80000000, b=4 -> c=0xF8000000. LUI b=0x1234 -> c=0x12340000. CMP a=b=5 -> zero=1, c=0.
- MULT a=-3, b=7 accepted -> busy=1 for exactly 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO issued the next cycle -> stall=1 throughout busy; c=0xFFFFFFEB on completion.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 -> LO=0xFFFFFFFF, HI=9. Rebuilt without ALU_DIV_EN -> DIV gives c=0, busy stays 0.
- ADD issued during busy MULT -> stall=0, correct c. Second MULT during busy -> stall=1 until busy falls, then accepted with zero bubble.
- rst asserted at iteration 10 of MULTU 0xFFFFFFFF × 2 -> next cycle busy=0, HI=LO=0. Following MFHI -> c=0.
